// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: fetch/flag inputs and datapath control strobes of the sequencer
interface exec_sequencer_if;
   logic [3:0] instr;
   logic       c_flag, z_flag, mem_ready, halt_req;
   logic       loadIR, incPC, loadPC, loadA, loadFlags, loadOut;
   logic [2:0] fun;
   logic       csRAM, weRAM, oeALU, oeIN, oeOprnd;
   logic       phase, halted, mem_err;
   logic [1:0] state;
   modport master (
      input  instr, c_flag, z_flag, mem_ready, halt_req,
      output loadIR, incPC, loadPC, loadA, loadFlags, loadOut, fun,
             csRAM, weRAM, oeALU, oeIN, oeOprnd, phase, halted, mem_err, state
   );
   modport slave (
      output instr, c_flag, z_flag, mem_ready, halt_req,
      input  loadIR, incPC, loadPC, loadA, loadFlags, loadOut, fun,
             csRAM, weRAM, oeALU, oeIN, oeOprnd, phase, halted, mem_err, state
   );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/execute FSM with RAM wait states, timeout and halt for the 4-bit accumulator CPU
module exec_sequencer #(
   parameter int unsigned MAX_WAIT = 8
) (
   input logic              clk,
   input logic              reset,
   exec_sequencer_if.master bus
);
   typedef enum logic [1:0] {FETCH = 2'b00, EXEC = 2'b01, MEM_WAIT = 2'b10, HALTED = 2'b11} state_t;
   state_t     st;
   logic [7:0] cnt;
   logic       mem_err;
   logic       busy, mem_op, jmp_op, imm_op, taken, tmo, wr_a, wr_f;
   logic [2:0] fn;
   assign busy   = (st == EXEC) || (st == MEM_WAIT);
   assign mem_op = (bus.instr[1:0] == 2'b11) || (bus.instr == 4'b0110);
   assign jmp_op = bus.instr inside {4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1100};
   assign imm_op = bus.instr inside {4'b0010, 4'b0100, 4'b1010, 4'b1110};
   assign taken  = bus.instr[2] | ((bus.instr[3] ? bus.z_flag : bus.c_flag) ^ bus.instr[0]);
   assign fn     = (bus.instr[3:1] == 3'b001) ? 3'b001 :
                   (bus.instr inside {4'b0100, 4'b0101, 4'b0110}) ? 3'b010 :
                   (bus.instr[3:1] == 3'b101) ? 3'b011 :
                   (bus.instr[3:1] == 3'b111) ? 3'b100 : 3'b000;
   assign wr_a   = fn inside {3'b010, 3'b011, 3'b100};
   assign wr_f   = fn inside {3'b001, 3'b011, 3'b100};
   assign tmo    = (st == MEM_WAIT) && !bus.mem_ready && (cnt == 8'(MAX_WAIT - 1));
   assign bus.phase   = busy;
   assign bus.halted  = st == HALTED;
   assign bus.mem_err = mem_err;
   assign bus.state   = st;
   // state, wait counter and sticky timeout flag
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st      <= FETCH;
         cnt     <= 8'd0;
         mem_err <= 1'b0;
      end else if (st == FETCH)
         st <= bus.halt_req ? HALTED : EXEC;
      else if (st == HALTED)
         st <= bus.halt_req ? HALTED : FETCH;
      else if (st == EXEC) begin
         st  <= (mem_op && !bus.mem_ready) ? MEM_WAIT : FETCH;
         cnt <= 8'd0;
      end else begin
         st      <= (bus.mem_ready || tmo) ? FETCH : MEM_WAIT;
         cnt     <= bus.mem_ready ? cnt : cnt + 8'd1;
         mem_err <= mem_err | tmo;
      end
   // control strobes decoded from state, opcode, flags and mem_ready; all low during reset
   always_comb begin
      bus.loadIR    = 1'b0;
      bus.incPC     = 1'b0;
      bus.loadPC    = 1'b0;
      bus.loadA     = 1'b0;
      bus.loadFlags = 1'b0;
      bus.loadOut   = 1'b0;
      bus.fun       = 3'b000;
      bus.csRAM     = 1'b0;
      bus.weRAM     = 1'b0;
      bus.oeALU     = 1'b0;
      bus.oeIN      = 1'b0;
      bus.oeOprnd   = 1'b0;
      if (!reset && st == FETCH && !bus.halt_req) begin
         bus.loadIR = 1'b1;
         bus.incPC  = 1'b1;
      end else if (!reset && busy && mem_op) begin
         bus.csRAM     = 1'b1;
         bus.weRAM     = bus.instr == 4'b0111;
         bus.oeALU     = bus.instr == 4'b0111;
         bus.fun       = fn;
         bus.loadA     = bus.mem_ready & wr_a;
         bus.loadFlags = bus.mem_ready & wr_f;
         bus.incPC     = bus.mem_ready | tmo;
      end else if (!reset && st == EXEC) begin
         bus.loadPC    = jmp_op & taken;
         bus.incPC     = jmp_op & ~taken;
         bus.oeIN      = bus.instr == 4'b0101;
         bus.oeALU     = bus.instr == 4'b1101;
         bus.loadOut   = bus.instr == 4'b1101;
         bus.oeOprnd   = imm_op;
         bus.fun       = fn;
         bus.loadA     = wr_a;
         bus.loadFlags = wr_f;
      end
   end
   a_bus_excl: assert property (@(posedge clk) disable iff (reset)
      $onehot0({bus.oeALU, bus.oeIN, bus.oeOprnd, bus.csRAM & ~bus.weRAM}));
   a_pc_excl: assert property (@(posedge clk) disable iff (reset) !(bus.loadPC && bus.incPC));
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: table-driven and directed checks of the exec_sequencer control strobes
module tb_exec_sequencer;
   localparam logic [18:0] L_IR = 19'h40000, I_PC = 19'h20000, L_PC = 19'h10000, L_A = 19'h08000;
   localparam logic [18:0] L_F = 19'h04000, L_O = 19'h02000;
   localparam logic [18:0] F1 = 19'h00400, F2 = 19'h00800, F3 = 19'h00C00, F4 = 19'h01000;
   localparam logic [18:0] CS = 19'h00200, WE = 19'h00100, OA = 19'h00080, OI = 19'h00040, OO = 19'h00020;
   localparam logic [18:0] PH = 19'h00010, HL = 19'h00008, ME = 19'h00004;
   localparam logic [18:0] S1 = 19'h00001, S2 = 19'h00002, S3 = 19'h00003;
   localparam logic [18:0] FE = L_IR | I_PC;
   typedef struct {
      logic [3:0]  i;
      logic        c, z, mr, hr;
      logic [18:0] e;
      string       n;
   } vec_t;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [18:0] obs;
   int          errors = 0;
   int          checks = 0;
   vec_t        tbl[$];
   exec_sequencer_if bi();
   exec_sequencer #(.MAX_WAIT(8)) dut (.clk(clk), .reset(reset), .bus(bi.master));
   always #5 clk = ~clk;
   assign obs = {bi.loadIR, bi.incPC, bi.loadPC, bi.loadA, bi.loadFlags, bi.loadOut, bi.fun,
                 bi.csRAM, bi.weRAM, bi.oeALU, bi.oeIN, bi.oeOprnd, bi.phase, bi.halted,
                 bi.mem_err, bi.state};
   function automatic vec_t mk(input logic [3:0] i, input logic c, z, mr, hr,
                               input logic [18:0] e, input string n);
      vec_t v;
      v.i = i; v.c = c; v.z = z; v.mr = mr; v.hr = hr; v.e = e; v.n = n;
      return v;
   endfunction
   task automatic check(input logic [18:0] e, input string n);
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, obs, e);
      end
   endtask
   task automatic cyc(input logic [3:0] i, input logic c, z, mr, hr,
                      input logic [18:0] e, input string n);
      bi.instr = i; bi.c_flag = c; bi.z_flag = z; bi.mem_ready = mr; bi.halt_req = hr;
      #1;
      check(e, n);
      @(negedge clk);
   endtask
   initial begin
      tbl.push_back(mk(4'b0100, 0, 0, 0, 0, FE, "lit_fetch"));
      tbl.push_back(mk(4'b0100, 0, 0, 0, 0, OO | F2 | L_A | PH | S1, "lit_exec"));
      tbl.push_back(mk(4'b0000, 0, 0, 0, 0, FE, "jc_fetch"));
      tbl.push_back(mk(4'b0000, 0, 0, 0, 0, I_PC | PH | S1, "jc_not_taken"));
      tbl.push_back(mk(4'b0000, 1, 0, 0, 0, FE, "jc_fetch2"));
      tbl.push_back(mk(4'b0000, 1, 0, 0, 0, L_PC | PH | S1, "jc_taken"));
      tbl.push_back(mk(4'b1001, 0, 0, 0, 0, FE, "jnz_fetch"));
      tbl.push_back(mk(4'b1001, 0, 0, 0, 0, L_PC | PH | S1, "jnz_taken"));
      tbl.push_back(mk(4'b1000, 1, 0, 0, 0, FE, "jz_fetch"));
      tbl.push_back(mk(4'b1000, 1, 0, 0, 0, I_PC | PH | S1, "jz_not_taken"));
      tbl.push_back(mk(4'b0001, 1, 1, 0, 0, FE, "jnc_fetch"));
      tbl.push_back(mk(4'b0001, 1, 1, 0, 0, I_PC | PH | S1, "jnc_not_taken"));
      tbl.push_back(mk(4'b1100, 0, 0, 0, 0, FE, "jmp_fetch"));
      tbl.push_back(mk(4'b1100, 0, 0, 0, 0, L_PC | PH | S1, "jmp_exec"));
      tbl.push_back(mk(4'b0010, 0, 0, 0, 0, FE, "cmpi_fetch"));
      tbl.push_back(mk(4'b0010, 0, 0, 0, 0, OO | F1 | L_F | PH | S1, "cmpi_exec"));
      tbl.push_back(mk(4'b0101, 0, 0, 0, 0, FE, "in_fetch"));
      tbl.push_back(mk(4'b0101, 0, 0, 0, 0, OI | F2 | L_A | PH | S1, "in_exec"));
      tbl.push_back(mk(4'b1010, 0, 0, 0, 0, FE, "addi_fetch"));
      tbl.push_back(mk(4'b1010, 0, 0, 0, 0, OO | F3 | L_A | L_F | PH | S1, "addi_exec"));
      tbl.push_back(mk(4'b1110, 0, 0, 0, 0, FE, "nandi_fetch"));
      tbl.push_back(mk(4'b1110, 0, 0, 0, 0, OO | F4 | L_A | L_F | PH | S1, "nandi_exec"));
      tbl.push_back(mk(4'b1101, 0, 0, 0, 0, FE, "out_fetch"));
      tbl.push_back(mk(4'b1101, 0, 0, 0, 0, OA | L_O | PH | S1, "out_exec"));
      tbl.push_back(mk(4'b0110, 0, 0, 0, 0, FE, "ld_fetch"));
      tbl.push_back(mk(4'b0110, 0, 0, 0, 0, CS | F2 | PH | S1, "ld_exec_wait"));
      tbl.push_back(mk(4'b0110, 0, 0, 0, 0, CS | F2 | PH | S2, "ld_wait1"));
      tbl.push_back(mk(4'b0110, 0, 0, 0, 0, CS | F2 | PH | S2, "ld_wait2"));
      tbl.push_back(mk(4'b0110, 0, 0, 1, 0, CS | F2 | L_A | I_PC | PH | S2, "ld_done"));
      tbl.push_back(mk(4'b0011, 0, 0, 1, 0, FE, "cmpm_fetch"));
      tbl.push_back(mk(4'b0011, 0, 0, 1, 0, CS | F1 | L_F | I_PC | PH | S1, "cmpm_zero_wait"));
      tbl.push_back(mk(4'b1011, 0, 0, 1, 0, FE, "addm_fetch"));
      tbl.push_back(mk(4'b1011, 0, 0, 1, 1, CS | F3 | L_A | L_F | I_PC | PH | S1, "addm_halt_ignored"));
      tbl.push_back(mk(4'b1011, 0, 0, 0, 1, 19'h0, "fetch_halt_req"));
      tbl.push_back(mk(4'b1011, 0, 0, 0, 1, HL | S3, "halted_hold"));
      tbl.push_back(mk(4'b1011, 0, 0, 0, 0, HL | S3, "halted_release"));
      tbl.push_back(mk(4'b1111, 0, 0, 0, 0, FE, "resume_fetch"));
      tbl.push_back(mk(4'b1111, 0, 0, 0, 0, CS | F4 | PH | S1, "nandm_exec_wait"));
      tbl.push_back(mk(4'b1111, 0, 0, 1, 0, CS | F4 | L_A | L_F | I_PC | PH | S2, "nandm_done"));
      bi.instr = 4'b0000; bi.c_flag = 1'b0; bi.z_flag = 1'b0; bi.mem_ready = 1'b0; bi.halt_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check(19'h0, "reset_state");
      reset = 1'b0;
      foreach (tbl[k]) cyc(tbl[k].i, tbl[k].c, tbl[k].z, tbl[k].mr, tbl[k].hr, tbl[k].e, tbl[k].n);
      cyc(4'b0110, 0, 0, 0, 0, FE, "ldmax_fetch");
      cyc(4'b0110, 0, 0, 0, 0, CS | F2 | PH | S1, "ldmax_exec");
      for (int w = 0; w < 7; w++) cyc(4'b0110, 0, 0, 0, 0, CS | F2 | PH | S2, "ldmax_wait");
      cyc(4'b0110, 0, 0, 1, 0, CS | F2 | L_A | I_PC | PH | S2, "ldmax_last_wait_ready");
      cyc(4'b0111, 0, 0, 0, 0, FE, "st_fetch_no_err");
      cyc(4'b0111, 0, 0, 0, 0, CS | WE | OA | PH | S1, "st_exec");
      for (int w = 0; w < 7; w++) cyc(4'b0111, 0, 0, 0, 0, CS | WE | OA | PH | S2, "st_wait");
      cyc(4'b0111, 0, 0, 0, 0, CS | WE | OA | I_PC | PH | S2, "st_timeout");
      cyc(4'b0100, 0, 0, 0, 0, FE | ME, "err_fetch");
      cyc(4'b0100, 0, 0, 0, 0, OO | F2 | L_A | PH | S1 | ME, "err_sticky_lit");
      cyc(4'b0110, 0, 0, 0, 0, FE | ME, "rst_ld_fetch");
      cyc(4'b0110, 0, 0, 0, 0, CS | F2 | PH | S1 | ME, "rst_ld_exec");
      cyc(4'b0110, 0, 0, 0, 0, CS | F2 | PH | S2 | ME, "rst_ld_wait");
      reset = 1'b1;
      #1;
      check(19'h0, "async_reset_mid_wait");
      reset = 1'b0;
      cyc(4'b0100, 0, 0, 0, 0, FE, "post_reset_fetch");
      for (int r = 0; r < 400; r++) begin
         bi.instr = 4'($urandom_range(0, 15));
         bi.c_flag = 1'($urandom_range(0, 1));
         bi.z_flag = 1'($urandom_range(0, 1));
         bi.mem_ready = $urandom_range(0, 3) == 0;
         bi.halt_req = $urandom_range(0, 7) == 0;
         #1;
         checks += 2;
         if (int'(bi.oeALU) + int'(bi.oeIN) + int'(bi.oeOprnd) + int'(bi.csRAM & ~bi.weRAM) > 1) begin
            errors++;
            $display("FAIL bus_excl: got %b%b%b%b expected at most one set",
                     bi.oeALU, bi.oeIN, bi.oeOprnd, bi.csRAM & ~bi.weRAM);
         end
         if (bi.loadPC && bi.incPC) begin
            errors++;
            $display("FAIL pc_excl: got loadPC=1 incPC=1 expected not both");
         end
         @(negedge clk);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle control unit for the 4-bit accumulator processor. It replaces the phase flip-flop and the combinational decoder with a four-state FSM. It sequences fetch and execute, drives every datapath control strobe (PC, fetch latch, tri-state bus enables, RAM, ALU function, accumulator, flags, outputs) and adds a wait-state handshake for slow RAM plus a halt/resume request. It sits between the fetch register (`instr`) and flags on one side and the datapath enables on the other.

## Interface
- `MAX_WAIT`, default 8: maximum MEM_WAIT cycles before a memory access is aborted (range 1–255).

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr` in 4: opcode from the fetch register.
- `c_flag`, `z_flag` in 1 each: registered flags.
- `mem_ready` in 1: RAM access complete this cycle.
- `halt_req` in 1: request to stop at an instruction boundary.
- `loadIR` out 1: fetch register load.
- `incPC`, `loadPC` out 1 each: program counter controls.
- `loadA`, `loadFlags`, `loadOut` out 1 each: register loads.
- `fun` out 3: ALU function. 000 = pass A, 001 = A−B, 010 = pass B, 011 = A+B, 100 = NAND.
- `csRAM`, `weRAM` out 1 each: RAM select and write.
- `oeALU`, `oeIN`, `oeOprnd` out 1 each: data-bus driver enables.
- `phase` out 1: high in EXEC and MEM_WAIT.
- `halted` out 1: high in HALTED.
- `mem_err` out 1: sticky flag, set when a memory access times out.
- `state` out 2: FETCH = 00, EXEC = 01, MEM_WAIT = 10, HALTED = 11.

## Operation
- Outputs are decoded combinationally from `state`, `instr`, the flags and `mem_ready`. Only `state`, the wait counter and `mem_err` are registered.
- Reset: state = FETCH, counter = 0, `mem_err` = 0. All control outputs are forced to 0 while `reset` = 1.

FETCH:
- If `halt_req` = 1: all strobes 0, next state HALTED.
- Otherwise: `loadIR` = 1 and `incPC` = 1, next state EXEC.

HALTED:
- All strobes 0, `halted` = 1.
- Returns to FETCH on the first cycle with `halt_req` = 0.

EXEC for non-memory opcodes (one cycle, then FETCH):
- 0000 JC, 0001 JNC, 1000 JZ, 1001 JNZ: if the condition is true, `loadPC`; otherwise `incPC` (skips the address byte).
- 1100 JMP: `loadPC`.
- 0010 CMPI: `oeOprnd`, fun 001, `loadFlags`.
- 0100 LIT: `oeOprnd`, fun 010, `loadA`.
- 0101 IN: `oeIN`, fun 010, `loadA`.
- 1010 ADDI: `oeOprnd`, fun 011, `loadA` + `loadFlags`.
- 1110 NANDI: `oeOprnd`, fun 100, `loadA` + `loadFlags`.
- 1101 OUT: `oeALU`, fun 000, `loadOut`.

Memory opcodes:
- Bus controls per opcode:
  - 0011 CMPM: fun 001, completes with `loadFlags`.
  - 0110 LD: fun 010, completes with `loadA`.
  - 0111 ST: `weRAM` + `oeALU`, fun 000.
  - 1011 ADDM: fun 011, completes with `loadA` + `loadFlags`.
  - 1111 NANDM: fun 100, completes with `loadA` + `loadFlags`.
- Every memory opcode asserts `csRAM` with its bus controls in EXEC and in every MEM_WAIT cycle.
- Completion: the opcode's loads plus `incPC` are asserted only in the cycle where `mem_ready` = 1. Next state is FETCH.
- EXEC with `mem_ready` = 1 completes with zero wait states. With `mem_ready` = 0, the FSM goes to MEM_WAIT and the counter is cleared.
- MEM_WAIT: the counter increments each cycle `mem_ready` = 0.
- Timeout: when the counter reaches `MAX_WAIT` with `mem_ready` still 0:
  - Only `incPC` is asserted (no loads, `weRAM` still asserted that cycle).
  - `mem_err` is set to 1.
  - Next state is FETCH.
- `mem_err` clears only on reset.

Invariants (assertions):
- At most one of `oeALU`, `oeIN`, `oeOprnd`, (`csRAM` & ~`weRAM`) is 1 in any cycle.
- `loadPC` and `incPC` are never both 1.
- `halt_req` is ignored outside FETCH. A pending instruction always finishes first.

## Timing
- Non-memory instruction: 2 cycles (FETCH, EXEC).
- Memory instruction: 2 + N cycles, where N is the number of MEM_WAIT cycles before `mem_ready`, with N ≤ `MAX_WAIT`.
- A timed-out access takes 2 + `MAX_WAIT` cycles.
- All registered changes take effect on the rising `clk` edge.
- `mem_ready` is sampled in the same cycle it is asserted (no extra latency).
- `halt_req` asserted in FETCH takes effect at the next edge.
- Resume: the cycle after `halt_req` falls is FETCH.
- Reset mid-MEM_WAIT: state returns to FETCH immediately, strobes drop asynchronously, counter and `mem_err` clear.

## Test plan
- Reset, then `instr` = 0100 (LIT): cycle 1 `loadIR` = `incPC` = 1; cycle 2 `oeOprnd` = `loadA` = 1, fun = 010; `state` returns to 00.
- JC with `c_flag` = 0, then `c_flag` = 1: not taken gives `incPC` = 1, `loadPC` = 0; taken gives `loadPC` = 1, `incPC` = 0.
- LD with `mem_ready` low 3 cycles: `csRAM` = 1 for 4 execute cycles; `loadA` and `incPC` pulse only in the 4th; total 5 cycles.
- ST with `MAX_WAIT` = 8 and `mem_ready` held 0: after 8 MEM_WAIT cycles `incPC` = 1 with no loads, `mem_err` = 1 and stays 1 through later instructions until reset.
- `halt_req` raised during ADDM EXEC: ADDM completes, next FETCH goes to HALTED with `halted` = 1 and no `loadIR`; dropping `halt_req` gives FETCH the next cycle.
- Reset asserted mid-MEM_WAIT: all strobes 0 immediately, `state` = 00, `mem_err` = 0; bus-exclusivity assertion is checked every cycle of a random opcode run.
